ws2812_chain_driver: RTL and testbench

Parametrised WS2812 serial driver for a chain of NUM_LEDS pixels.
- Holds a register-based frame buffer written through a simple write port.
- Streams the buffer as GRB, MSB first, with exact bit timing, then holds the latch/reset low gap.
- Supports single-shot frames (start pulse) and continuous auto-refresh.
- Sits between the fade/pattern generators and the board-level WS2812 data pin.

---
 rtl/ws2812_chain_driver.sv | 99 +++++++++
 tb/tb_ws2812_chain_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: WS2812 GRB chain driver with frame buffer; define WS2812_BRIGHTNESS_EN for per-pixel brightness scaling
module ws2812_chain_driver #(
    parameter int NUM_LEDS = 8,
    parameter int T0H_CYC = 18,
    parameter int T1H_CYC = 35,
    parameter int TBIT_CYC = 63,
    parameter int TRST_CYC = 3000,
    localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    input  logic          refresh_en,
    output logic          busy,
    output logic          frame_done,
    output logic          ws2812_out
);
    localparam int CMAX = TBIT_CYC > TRST_CYC ? TBIT_CYC : TRST_CYC;
    localparam int CW = CMAX > 4 ? $clog2(CMAX) : 2;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, LATCH = 2'd3;
    localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);
    logic [23:0] fb [NUM_LEDS];
    logic [1:0] state;
    logic [AW-1:0] pix, nxt;
    logic [4:0] bitn;
    logic [CW-1:0] cnt;
    logic [23:0] sh;
    logic pend, bit_end, gap_end, go, hi;
    function automatic logic [7:0] sc(input logic [7:0] c);
`ifdef WS2812_BRIGHTNESS_EN
        logic [16:0] m;
        m = 17'(c) * 17'({1'b0, brightness} + 9'd1);
        return m[15:8];
`else
        return c;
`endif
    endfunction
    function automatic logic [23:0] grb(input logic [23:0] p);
        return {sc(p[15:8]), sc(p[23:16]), sc(p[7:0])};
    endfunction
    always_comb begin
        nxt = pix + 1'b1;
        bit_end = state == SEND && cnt == CW'(TBIT_CYC - 1);
        gap_end = state == LATCH && cnt == CW'(TRST_CYC - 1);
        go = state == IDLE ? (start | refresh_en | pend) : gap_end & (refresh_en | pend);
        hi = state == SEND && cnt < (sh[23] ? CW'(T1H_CYC) : CW'(T0H_CYC));
        busy = state != IDLE;
        frame_done = gap_end;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) fb[i] <= '0;
            state <= IDLE;
            pix <= '0;
            bitn <= '0;
            cnt <= '0;
            sh <= '0;
            pend <= 1'b0;
            ws2812_out <= 1'b0;
        end else begin
            if (wr_en && wr_addr <= LAST) fb[wr_addr] <= wr_data;
            ws2812_out <= hi;
            pend <= go ? 1'b0 : pend | (start & busy);
            case (state)
                IDLE: state <= go ? LOAD : IDLE;
                LOAD: begin
                    state <= SEND;
                    pix <= '0;
                    bitn <= 5'd23;
                    cnt <= '0;
                    sh <= grb(fb[0]);
                end
                SEND: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end && bitn != 5'd0) begin
                        sh <= sh << 1;
                        bitn <= bitn - 1'b1;
                    end else if (bit_end && pix == LAST) begin
                        state <= LATCH;
                    end else if (bit_end) begin
                        pix <= nxt;
                        bitn <= 5'd23;
                        sh <= grb(fb[nxt]);
                    end
                end
                default: begin
                    cnt <= gap_end ? '0 : cnt + 1'b1;
                    if (gap_end) state <= go ? LOAD : IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: frame-level model plus directed checks for ws2812_chain_driver
module tb_ws2812_chain_driver;
    localparam int N = 3, T0 = 18, T1 = 35, TB = 63, TR = 3000, AW = 2;
    localparam int PIX = 24 * TB;
    localparam int FL = 1 + N * PIX + TR;
    logic clk = 0, reset_n = 0, wr_en = 0, start = 0, refresh_en = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic busy, frame_done, ws2812_out;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] brightness = 8'hFF;
`endif
    int tests = 0, fails = 0, prints = 0;
    always #5 clk = ~clk;

    ws2812_chain_driver #(.NUM_LEDS(N), .T0H_CYC(T0), .T1H_CYC(T1), .TBIT_CYC(TB), .TRST_CYC(TR)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .refresh_en(refresh_en),
        .busy(busy),
        .frame_done(frame_done),
        .ws2812_out(ws2812_out)
    );

    // Model: a frame is a cycle index k (0 = load cycle); pixel p is snapshotted at k = p*PIX.
    logic [23:0] mbuf [N];
    logic [23:0] snap [N];
    bit infr, pend;
    int k;
    function automatic logic [7:0] msc(input logic [7:0] c);
`ifdef WS2812_BRIGHTNESS_EN
        int v;
        v = int'(c) * (int'(brightness) + 1);
        return 8'(v / 256);
`else
        return c;
`endif
    endfunction
    function automatic logic [23:0] mgrb(input logic [23:0] p);
        return {msc(p[15:8]), msc(p[23:16]), msc(p[7:0])};
    endfunction
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            infr = 0;
            pend = 0;
            k = 0;
            for (int i = 0; i < N; i++) mbuf[i] = '0;
        end else begin
            if (infr && k % PIX == 0 && k / PIX < N) snap[k / PIX] = mgrb(mbuf[k / PIX]);
            if (infr) begin
                if (k == FL - 1) begin
                    if (refresh_en || pend) begin
                        k = 0;
                        pend = 0;
                    end else begin
                        infr = 0;
                        pend = start;
                    end
                end else begin
                    k++;
                    if (start) pend = 1;
                end
            end else if (start || refresh_en || pend) begin
                infr = 1;
                k = 0;
                pend = 0;
            end
            if (wr_en && int'(wr_addr) < N) mbuf[wr_addr] = wr_data;
        end
    end

    int s, b, ph;
    bit bv;
    logic eo, eb, ef;
    always @(negedge clk) begin
        s = k - 2;
        eo = 0;
        if (infr && s >= 0 && s < N * PIX) begin
            b = s / TB;
            ph = s % TB;
            bv = snap[b / 24][23 - (b % 24)];
            eo = ph < (bv ? T1 : T0);
        end
        eb = infr;
        ef = infr && k == FL - 1;
        tests++;
        if (ws2812_out !== eo || busy !== eb || frame_done !== ef) begin
            fails++;
            if (prints < 20) $display("FAIL model k=%0d: out/busy/done=%b%b%b required %b%b%b", k, ws2812_out, busy, frame_done, eo, eb, ef);
            prints++;
        end
    end

    bit bits[$];
    int widths[$];
    int hic = 0;
    always @(negedge clk) begin
        if (ws2812_out) hic++;
        else if (hic > 0) begin
            bits.push_back(hic > 26);
            widths.push_back(hic);
            hic = 0;
        end
    end
    function automatic int byte_at(input int i);
        int v = 0;
        if (bits.size() < i * 8 + 8) return -1;
        for (int j = 0; j < 8; j++) v = (v << 1) | int'(bits[i * 8 + j]);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask
    task automatic clr();
        bits.delete();
        widths.delete();
    endtask
    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask
    task automatic wr(input int a, input logic [23:0] d);
        wr_en = 1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask
    task automatic wait_done(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2 * FL);
        if (!frame_done) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout frame_done=0 required 1", nm);
        end
    endtask
    task automatic chk_bytes(input string nm, input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int e[9] = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        for (int i = 0; i < 9; i++) chk($sformatf("%s byte%0d", nm, i), byte_at(i), e[i]);
    endtask

    int n;
    initial begin
        repeat (3) @(negedge clk);
        chk("reset out", int'(ws2812_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(frame_done), 0);
        reset_n = 1;
        @(negedge clk);
        clr();
        pulse_start();
        chk("t1 busy in load", int'(busy), 1);
        wait_done("t1 done", n);
        chk("t1 done latency", n, 7536);
        @(negedge clk);
        chk("t1 busy after", int'(busy), 0);
        chk("t1 bit count", bits.size(), 72);
        chk("t1 zero width", widths.size() > 0 ? widths[0] : -1, 18);
        chk_bytes("t1", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        wr(0, 24'hFF0000);
        wr(1, 24'h00FF00);
        clr();
        pulse_start();
        wait_done("t2 done", n);
        chk_bytes("t2", 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t2 one width", widths.size() > 8 ? widths[8] : -1, 35);

        refresh_en = 1;
        wait_done("t3 first", n);
        wait_done("t3 second", n);
        chk("t3 refresh period", n, 6025 + 24 * TB);
        repeat (1000) @(negedge clk);
        refresh_en = 0;
        wait_done("t3 last", n);
        @(negedge clk);
        chk("t3 busy drop", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("t3 stays idle", int'(busy), 0);

        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        repeat (300) @(negedge clk);
        wr(3, 24'hFFFFFF);
        pulse_start();
        wait_done("t4 first", n);
        clr();
        wait_done("t4 extra", n);
        chk("t4 extra period", n, FL);
        chk_bytes("t4", 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (20) @(negedge clk);
        chk("t4 single extra", int'(busy), 0);

        wr(1, 24'hFFFFFF);
        pulse_start();
        repeat ((24 + 10) * TB + 5 + 2) @(negedge clk);
        chk("t5 high before reset", int'(ws2812_out), 1);
        #2 reset_n = 0;
        #1;
        chk("t5 out on reset", int'(ws2812_out), 0);
        chk("t5 busy on reset", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        clr();
        pulse_start();
        wait_done("t5 done", n);
        chk_bytes("t5", 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'h7F;
        wr(0, 24'hFF8040);
        clr();
        pulse_start();
        wait_done("t6 done", n);
        chk("t6 G", byte_at(0), 8'h40);
        chk("t6 R", byte_at(1), 8'h7F);
        chk("t6 B", byte_at(2), 8'h20);
        brightness = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
